// File: rtl/pred_range_scan.sv
// Range scan controller: steps cand from lo to hi, one value per clock, and
// gathers hit count and first hit from the downstream word predicate.
module pred_range_scan #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      lo,
  input  logic [31:0]      hi,
  input  logic             abort,
  input  logic             pred,
  output logic [31:0]      cand,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] hit_count,
  output logic [31:0]      first_hit,
  output logic             first_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] hi_lat;
  logic        range_ok;
  logic        at_end;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign range_ok = (lo <= hi);
  // Compare before increment so hi = all-ones ends without wrapping cand.
  assign at_end   = (cand == hi_lat);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = range_ok ? RUN : DONE;
      RUN:     if (abort || at_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand        <= '0;
      hi_lat      <= '0;
      aborted     <= 1'b0;
      hit_count   <= '0;
      first_hit   <= '0;
      first_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            aborted     <= 1'b0;
            hit_count   <= '0;
            first_hit   <= '0;
            first_valid <= 1'b0;
            if (range_ok) begin
              hi_lat <= hi;
              cand   <= lo;
            end
          end
        end
        RUN: begin
          if (abort) begin
            aborted <= 1'b1;
          end else begin
            if (pred) begin
              hit_count <= sat_inc(hit_count);
              if (!first_valid) begin
                first_hit   <= cand;
                first_valid <= 1'b1;
              end
            end
            if (!at_end) cand <= cand + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
